// File: rtl/phase1_sequencer.sv
// Phase-1 control for the position/velocity ring force pass: masked, pipelined status
// reduction feeding a LOAD/ROTATE/DRAIN sequencer with drain quiescence filter and watchdog.
module phase1_sequencer #(
  parameter int unsigned N_CELL        = 27,
  parameter int unsigned REDUCE_STAGES = 2,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned TIMEOUT_W     = 16,
  parameter int unsigned BATCH_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CTL_READY,
  input  logic [N_CELL-1:0]  cell_en,
  input  logic [N_CELL-1:0]  done_batch,
  input  logic [N_CELL-1:0]  done_all,
  input  logic [N_CELL-1:0]  in_flight,
  input  logic [N_CELL-1:0]  pipe_done,
  input  logic [N_CELL-1:0]  v_rempty,
  output logic [1:0]         dispatch,
  output logic               double_buffer,
  output logic [BATCH_W-1:0] batch_cnt,
  output logic               CTL_DONE,
  output logic               err_timeout
);

  localparam int unsigned BlankW = $clog2(REDUCE_STAGES + 2);
  localparam int unsigned QuietW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [BlankW-1:0]    BlankInit = BlankW'(REDUCE_STAGES + 1);
  localparam logic [QuietW-1:0]    QuietLast = QuietW'(DRAIN_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WdLast    = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  localparam logic [1:0] DispHold   = 2'b00;
  localparam logic [1:0] DispLoad   = 2'b01;
  localparam logic [1:0] DispRotate = 2'b10;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone, StErr} state_e;

  state_e              state_q;
  logic [N_CELL-1:0]   mask_q;
  logic [BlankW-1:0]   blank_q;
  logic [QuietW-1:0]   quiet_q;
  logic [TIMEOUT_W-1:0] wd_q;

  // Flag bit order: {quiet, busy, fin_all, fin_batch}
  logic [3:0] red_in;
  logic [3:0] red_q [REDUCE_STAGES];

  // Masked cells look finished, idle and empty.
  always_comb begin
    red_in    = '0;
    red_in[0] = &(done_batch | ~mask_q);
    red_in[1] = &(done_all | ~mask_q);
    red_in[2] = |(in_flight & mask_q);
    red_in[3] = &((pipe_done & v_rempty) | ~mask_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(REDUCE_STAGES); i++) red_q[i] <= '0;
    end else begin
      red_q[0] <= red_in;
      for (int i = 1; i < int'(REDUCE_STAGES); i++) red_q[i] <= red_q[i-1];
    end
  end

  logic fin_batch, fin_all, busy, quiet, flags_live, wd_expire;

  always_comb begin
    fin_batch  = red_q[REDUCE_STAGES-1][0];
    fin_all    = red_q[REDUCE_STAGES-1][1];
    busy       = red_q[REDUCE_STAGES-1][2];
    quiet      = red_q[REDUCE_STAGES-1][3];
    flags_live = (blank_q == '0);
    wd_expire  = (wd_q == WdLast);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      dispatch      <= DispHold;
      double_buffer <= 1'b0;
      batch_cnt     <= '0;
      CTL_DONE      <= 1'b0;
      err_timeout   <= 1'b0;
      mask_q        <= '0;
      blank_q       <= '0;
      quiet_q       <= '0;
      wd_q          <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (CTL_READY) begin
            state_q   <= StLoad;
            dispatch  <= DispLoad;
            batch_cnt <= '0;
            mask_q    <= cell_en;
            wd_q      <= '0;
          end
        end
        StLoad: begin
          state_q  <= StRun;
          dispatch <= DispRotate;
          blank_q  <= BlankInit;
          wd_q     <= '0;
          if (batch_cnt != '1) batch_cnt <= batch_cnt + 1'b1;
        end
        StRun: begin
          // Reduced flags still describe the previous batch until the blank window expires.
          if (!flags_live) blank_q <= blank_q - 1'b1;
          if (flags_live && fin_batch && fin_all) begin
            state_q  <= StDrain;
            dispatch <= DispHold;
            quiet_q  <= '0;
            wd_q     <= '0;
          end else if (flags_live && fin_batch) begin
            state_q  <= StLoad;
            dispatch <= DispLoad;
            wd_q     <= '0;
          end else if (wd_expire) begin
            state_q     <= StErr;
            dispatch    <= DispHold;
            err_timeout <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StDrain: begin
          if (!busy && quiet) begin
            wd_q <= '0;
            if (quiet_q == QuietLast) begin
              state_q       <= StDone;
              CTL_DONE      <= 1'b1;
              double_buffer <= ~double_buffer;
              quiet_q       <= '0;
            end else begin
              quiet_q <= quiet_q + 1'b1;
            end
          end else begin
            quiet_q <= '0;
            if (wd_expire) begin
              state_q     <= StErr;
              err_timeout <= 1'b1;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
        end
        StDone: begin
          if (!CTL_READY) begin
            state_q  <= StIdle;
            CTL_DONE <= 1'b0;
          end
        end
        StErr: begin
          dispatch <= DispHold;
          CTL_DONE <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          dispatch <= DispHold;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase1_sequencer.sv
// Directed bench for phase1_sequencer: expected output transitions (with cycle gaps)
// are queued by the stimulus and checked by an independent monitor.
module tb_phase1_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CTL_READY = 1'b0;
  logic [3:0] cell_en, done_batch, done_all, in_flight, pipe_done, v_rempty;
  logic [1:0] dispatch;
  logic       double_buffer;
  logic [7:0] batch_cnt;
  logic       CTL_DONE, err_timeout;

  phase1_sequencer #(
    .N_CELL       (4),
    .REDUCE_STAGES(2),
    .DRAIN_CYCLES (4),
    .TIMEOUT_W    (4),
    .BATCH_W      (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .CTL_READY    (CTL_READY),
    .cell_en      (cell_en),
    .done_batch   (done_batch),
    .done_all     (done_all),
    .in_flight    (in_flight),
    .pipe_done    (pipe_done),
    .v_rempty     (v_rempty),
    .dispatch     (dispatch),
    .double_buffer(double_buffer),
    .batch_cnt    (batch_cnt),
    .CTL_DONE     (CTL_DONE),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] disp;
    logic [7:0] bcnt;
    logic       db;
    logic       done;
    logic       err;
    int         gap;  // cycles since previous output change, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void push_exp(string name, logic [1:0] disp, logic [7:0] bcnt, logic db,
                                   logic done, logic err, int gap);
    exp_t e;
    e.name = name; e.disp = disp; e.bcnt = bcnt; e.db = db;
    e.done = done; e.err = err; e.gap = gap;
    exp_q.push_back(e);
  endfunction

  // Monitor: every change of the output tuple consumes one expected record.
  logic [12:0] mon_cur, mon_prev, mon_want;
  exp_t        mon_e;
  bit          mon_first = 1'b1;
  int          mon_cyc = 0;
  int          mon_last = 0;

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      mon_cur = {dispatch, batch_cnt, double_buffer, CTL_DONE, err_timeout};
      if (mon_first || mon_cur !== mon_prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got disp=%b bcnt=%0d db=%b done=%b err=%b, required no change",
                   dispatch, batch_cnt, double_buffer, CTL_DONE, err_timeout);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_want = {mon_e.disp, mon_e.bcnt, mon_e.db, mon_e.done, mon_e.err};
          if (mon_cur !== mon_want) begin
            fails++;
            $display("FAIL %s: got disp=%b bcnt=%0d db=%b done=%b err=%b, required disp=%b bcnt=%0d db=%b done=%b err=%b",
                     mon_e.name, dispatch, batch_cnt, double_buffer, CTL_DONE, err_timeout,
                     mon_e.disp, mon_e.bcnt, mon_e.db, mon_e.done, mon_e.err);
          end
          if (mon_e.gap >= 0) begin
            tests++;
            if (mon_cyc - mon_last != mon_e.gap) begin
              fails++;
              $display("FAIL %s_gap: got %0d cycles, required %0d", mon_e.name,
                       mon_cyc - mon_last, mon_e.gap);
            end
          end
        end
        mon_first = 1'b0;
        mon_prev  = mon_cur;
        mon_last  = mon_cyc;
      end
    end
  end

  task automatic wait_load(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (dispatch != 2'b01 && n < 200);
    tests++;
    if (dispatch != 2'b01) begin
      fails++;
      $display("FAIL %s_wait_load: got dispatch=%b after %0d cycles, required 01", name, dispatch, n);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!CTL_DONE && n < 200);
    tests++;
    if (!CTL_DONE) begin
      fails++;
      $display("FAIL %s_wait_done: got CTL_DONE=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic wait_err(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 200);
    tests++;
    if (!err_timeout) begin
      fails++;
      $display("FAIL %s_wait_err: got err_timeout=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic set_defaults();
    cell_en = 4'b1111; done_batch = 4'b0000; done_all = 4'b0000;
    in_flight = 4'b0000; pipe_done = 4'b1111; v_rempty = 4'b1111;
  endtask

  task automatic pulse_done(input logic [3:0] batch, input logic [3:0] all);
    done_batch = batch; done_all = all;
    @(negedge clk);
    done_batch = 4'b0000; done_all = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish before 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    set_defaults();
    // 1: reset with random inputs
    push_exp("reset", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      CTL_READY = 1'($urandom); cell_en = 4'($urandom); done_batch = 4'($urandom);
      done_all = 4'($urandom); in_flight = 4'($urandom); pipe_done = 4'($urandom);
      v_rempty = 4'($urandom);
    end
    @(negedge clk);
    CTL_READY = 1'b0;
    set_defaults();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 2: three batches, done_all with the third
    push_exp("t2_load1", 2'b01, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    push_exp("t2_run1",  2'b10, 8'd1, 1'b0, 1'b0, 1'b0, 1);
    push_exp("t2_load2", 2'b01, 8'd1, 1'b0, 1'b0, 1'b0, 5);
    push_exp("t2_run2",  2'b10, 8'd2, 1'b0, 1'b0, 1'b0, 1);
    push_exp("t2_load3", 2'b01, 8'd2, 1'b0, 1'b0, 1'b0, 5);
    push_exp("t2_run3",  2'b10, 8'd3, 1'b0, 1'b0, 1'b0, 1);
    push_exp("t2_drain", 2'b00, 8'd3, 1'b0, 1'b0, 1'b0, 5);
    push_exp("t2_done",  2'b00, 8'd3, 1'b1, 1'b1, 1'b0, 4);
    push_exp("t2_idle",  2'b00, 8'd3, 1'b1, 1'b0, 1'b0, 4);
    CTL_READY = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wait_load("t2");
      repeat (3) @(negedge clk);
      pulse_done(4'b1111, (b == 2) ? 4'b1111 : 4'b0000);
    end
    wait_done("t2");
    repeat (3) @(negedge clk);
    CTL_READY = 1'b0;
    repeat (3) @(negedge clk);

    // 3: done_batch held high across LOAD
    push_exp("t3_load1", 2'b01, 8'd0, 1'b1, 1'b0, 1'b0, -1);
    push_exp("t3_run1",  2'b10, 8'd1, 1'b1, 1'b0, 1'b0, 1);
    push_exp("t3_load2", 2'b01, 8'd1, 1'b1, 1'b0, 1'b0, 4);
    push_exp("t3_run2",  2'b10, 8'd2, 1'b1, 1'b0, 1'b0, 1);
    push_exp("t3_drain", 2'b00, 8'd2, 1'b1, 1'b0, 1'b0, 4);
    push_exp("t3_done",  2'b00, 8'd2, 1'b0, 1'b1, 1'b0, 4);
    push_exp("t3_idle",  2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1);
    done_batch = 4'b1111;
    CTL_READY = 1'b1;
    wait_load("t3a");
    wait_load("t3b");
    done_all = 4'b1111;
    wait_done("t3");
    CTL_READY = 1'b0;
    set_defaults();
    repeat (3) @(negedge clk);

    // 4: mask 0101, cells 1,3 stuck busy; CTL_READY dropped mid-pass
    push_exp("t4_load",  2'b01, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    push_exp("t4_run",   2'b10, 8'd1, 1'b0, 1'b0, 1'b0, 1);
    push_exp("t4_drain", 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 5);
    push_exp("t4_done",  2'b00, 8'd1, 1'b1, 1'b1, 1'b0, 4);
    push_exp("t4_idle",  2'b00, 8'd1, 1'b1, 1'b0, 1'b0, 1);
    cell_en = 4'b0101; in_flight = 4'b1010; pipe_done = 4'b0101; v_rempty = 4'b0101;
    CTL_READY = 1'b1;
    wait_load("t4");
    @(negedge clk);
    CTL_READY = 1'b0;
    repeat (2) @(negedge clk);
    pulse_done(4'b0101, 4'b0101);
    wait_done("t4");
    @(negedge clk);
    set_defaults();
    repeat (3) @(negedge clk);

    // 6: watchdog, then reset clears ERR and double_buffer
    push_exp("t6_load", 2'b01, 8'd0, 1'b1, 1'b0, 1'b0, -1);
    push_exp("t6_run",  2'b10, 8'd1, 1'b1, 1'b0, 1'b0, 1);
    push_exp("t6_err",  2'b00, 8'd1, 1'b1, 1'b0, 1'b1, 15);
    CTL_READY = 1'b1;
    wait_load("t6");
    wait_err("t6");
    CTL_READY = 1'b0;
    repeat (5) @(negedge clk);
    push_exp("t6_reset", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 5: in_flight glitch during drain at quiet count 3
    push_exp("t5_load",  2'b01, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    push_exp("t5_run",   2'b10, 8'd1, 1'b0, 1'b0, 1'b0, 1);
    push_exp("t5_drain", 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 5);
    push_exp("t5_done",  2'b00, 8'd1, 1'b1, 1'b1, 1'b0, 8);
    push_exp("t5_idle",  2'b00, 8'd1, 1'b1, 1'b0, 1'b0, 1);
    CTL_READY = 1'b1;
    wait_load("t5");
    repeat (3) @(negedge clk);
    pulse_done(4'b1111, 4'b1111);
    repeat (3) @(negedge clk);
    in_flight = 4'b0100;
    @(negedge clk);
    in_flight = 4'b0000;
    wait_done("t5");
    CTL_READY = 1'b0;
    repeat (3) @(negedge clk);

    // 7: reset mid-pass
    push_exp("t7_load",  2'b01, 8'd0, 1'b1, 1'b0, 1'b0, -1);
    push_exp("t7_run",   2'b10, 8'd1, 1'b1, 1'b0, 1'b0, 1);
    push_exp("t7_reset", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    CTL_READY = 1'b1;
    wait_load("t7");
    @(negedge clk);
    #2 reset = 1'b0;
    CTL_READY = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d unconsumed, required 0 (next %s)", exp_q.size(),
               exp_q[0].name);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
